lcd_fb_arbiter: RTL and testbench

Shares one single-word framebuffer memory port between the LCD line fetcher and a host writer, such as the K210 or MCU path. On each line request from the LCD timing generator, it fetches one line of pixels into a ping-pong line buffer. Between display bursts it interleaves bounded host writes. It sits between the timing generator / line buffer and the memory controller, and flags underrun when a line is not fetched before the next request.

---
 rtl/lcd_pkg.sv | 17 +
 rtl/lcd_fetch_addr.sv | 53 +++++
 rtl/lcd_fb_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_fb_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD framebuffer arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    HOST = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W = 22;
  localparam int DEF_DATA_W = 16;
  // {bank, word index[9:0]}
  localparam int LB_ADDR_W  = 11;

endpackage

// File: rtl/lcd_fetch_addr.sv
// Display fetch address generator: line base multiply-add, word index and burst counters.
// Latency: start_addr is combinational from start_num; the counters update on the clock edge.
// Backpressure: only advances on word_ack, so it holds while the memory port stalls.
// Ports: line_start/start_num load a new line; word_ack steps idx/burst; cur_addr/next_addr
//        address the word in flight and the one after it; last/burst_end flag boundaries.
module lcd_fetch_addr
  import lcd_pkg::*;
#(
  parameter int          ADDR_W     = DEF_ADDR_W,
  parameter int          LINE_WORDS = 800,
  parameter int          BURST_LEN  = 16,
  parameter int unsigned FB_BASE    = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              line_start,
  input  logic [9:0]        start_num,
  input  logic              word_ack,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic [9:0]        idx,
  output logic              last,
  output logic              burst_end
);

  logic [ADDR_W-1:0] base;
  logic [9:0]        bcnt;

  // Everything is truncated to ADDR_W, so addresses past the top of memory wrap silently.
  assign start_addr = ADDR_W'(FB_BASE) + ADDR_W'(start_num) * ADDR_W'(LINE_WORDS);
  assign cur_addr   = base + ADDR_W'(idx);
  assign next_addr  = base + ADDR_W'(idx) + ADDR_W'(1);
  assign last       = (idx == 10'(LINE_WORDS - 1));
  assign burst_end  = (bcnt == 10'(BURST_LEN - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      base <= '0;
      idx  <= '0;
      bcnt <= '0;
    end else if (line_start) begin
      // A new line overrides any ack landing in the same cycle (abandon case).
      base <= start_addr;
      idx  <= '0;
      bcnt <= '0;
    end else if (word_ack) begin
      idx  <= idx + 10'd1;
      bcnt <= burst_end ? 10'd0 : bcnt + 10'd1;
    end
  end

endmodule

// File: rtl/lcd_fb_arbiter.sv
// Shares one single-word framebuffer port between the LCD line fetcher and a host writer.
// Latency: line_req -> mem_req 1 cycle; lb_* 1 cycle after each read ack; line_done 1 after last lb_we.
// Backpressure: every transaction is held until mem_ack; host is held off by up to BURST_LEN reads.
// Ports: line_req/line_num from timing generator; host_* write port; mem_* to memory controller;
//        lb_* ping-pong line buffer write; line_done per completed line; underrun sticky flag.
module lcd_fb_arbiter
  import lcd_pkg::*;
#(
  parameter int          ADDR_W     = DEF_ADDR_W,
  parameter int          DATA_W     = DEF_DATA_W,
  parameter int          LINE_WORDS = 800,
  parameter int          BURST_LEN  = 16,
  parameter int          HOST_MAX   = 4,
  parameter int unsigned FB_BASE    = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 line_req,
  input  logic [9:0]           line_num,
  input  logic                 host_req,
  input  logic [ADDR_W-1:0]    host_addr,
  input  logic [DATA_W-1:0]    host_wdata,
  output logic                 host_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 lb_we,
  output logic [LB_ADDR_W-1:0] lb_addr,
  output logic [DATA_W-1:0]    lb_wdata,
  output logic                 line_done,
  output logic                 underrun
);

  arb_state_t        state, state_nx;
  logic              pend, line_act, bank, done_d1;
  logic [9:0]        pend_num, new_num, f_idx;
  logic [7:0]        hcnt;
  logic              new_line, d_ack;
  logic              hold, start, rd_nxt, rd_res, wr;
  logic [ADDR_W-1:0] f_start_addr, f_cur_addr, f_next_addr;
  logic              f_last, f_burst_end;

  assign host_ack = mem_ack & (state == HOST);
  assign d_ack    = mem_ack & mem_req & (state == DISP);
  // A fresh line_req always beats an older latched one.
  assign new_line = line_req | pend;
  assign new_num  = line_req ? line_num : pend_num;

  lcd_fetch_addr #(
    .ADDR_W    (ADDR_W),
    .LINE_WORDS(LINE_WORDS),
    .BURST_LEN (BURST_LEN),
    .FB_BASE   (FB_BASE)
  ) u_fetch (
    .CLK       (CLK),
    .RST       (RST),
    .line_start(start),
    .start_num (new_num),
    .word_ack  (d_ack),
    .start_addr(f_start_addr),
    .cur_addr  (f_cur_addr),
    .next_addr (f_next_addr),
    .idx       (f_idx),
    .last      (f_last),
    .burst_end (f_burst_end)
  );

  // Decisions are only taken at word boundaries: no request outstanding, or its ack cycle.
  always_comb begin
    state_nx = state;
    hold     = 1'b0;
    start    = 1'b0;
    rd_nxt   = 1'b0;
    rd_res   = 1'b0;
    wr       = 1'b0;
    case (state)
      IDLE: begin
        if (new_line) begin
          state_nx = DISP;
          start    = 1'b1;
        end else if (host_req) begin
          state_nx = HOST;
          wr       = 1'b1;
        end
      end
      DISP: begin
        if (!mem_ack) begin
          hold = 1'b1;
        end else if (new_line) begin
          start = 1'b1;
        end else if (f_last) begin
          state_nx = IDLE;
        end else if (f_burst_end && host_req) begin
          state_nx = HOST;
          wr       = 1'b1;
        end else begin
          rd_nxt = 1'b1;
        end
      end
      HOST: begin
        if (mem_req) begin
          if (!mem_ack) begin
            hold = 1'b1;
          end else if (new_line) begin
            state_nx = DISP;
            start    = 1'b1;
          end else if (hcnt == 8'(HOST_MAX - 1)) begin
            state_nx = line_act ? DISP : IDLE;
            rd_res   = line_act;
          end
          // Otherwise drop mem_req for a cycle: the host only presents its next word
          // the cycle after host_ack, so it cannot be issued on the ack edge.
        end else if (new_line) begin
          state_nx = DISP;
          start    = 1'b1;
        end else if (host_req) begin
          wr = 1'b1;
        end else begin
          state_nx = line_act ? DISP : IDLE;
          rd_res   = line_act;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lb_we     <= 1'b0;
      lb_addr   <= '0;
      lb_wdata  <= '0;
      done_d1   <= 1'b0;
      line_done <= 1'b0;
      bank      <= 1'b0;
      underrun  <= 1'b0;
      pend      <= 1'b0;
      pend_num  <= '0;
      line_act  <= 1'b0;
      hcnt      <= '0;
    end else begin
      state <= state_nx;

      if (start) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= f_start_addr;
      end else if (rd_nxt) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= f_next_addr;
      end else if (rd_res) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= f_cur_addr;
      end else if (wr) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
      end else if (!hold) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end

      if (state != HOST)
        hcnt <= '0;
      else if (host_ack && mem_req)
        hcnt <= hcnt + 8'd1;

      lb_we <= d_ack;
      if (d_ack) begin
        lb_addr  <= {bank, f_idx};
        lb_wdata <= mem_rdata;
      end

      // line_done trails the final lb_we by one cycle; the bank flips with it.
      done_d1   <= d_ack & f_last;
      line_done <= done_d1;
      bank      <= bank ^ done_d1;

      if (start)
        line_act <= 1'b1;
      else if (d_ack && f_last)
        line_act <= 1'b0;

      pend <= start ? 1'b0 : (pend | line_req);
      if (line_req)
        pend_num <= line_num;

      underrun <= underrun | (line_req & (pend | line_act));
    end
  end

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Self-checking bench for lcd_fb_arbiter (LINE_WORDS=32, BURST_LEN=8, HOST_MAX=2).
// Latency: n/a. Backpressure: memory model acks after ack_dly cycles of mem_req.
// A second instance with FB_BASE = 2^22-32 shares all stimulus to check address wrap.
module tb_lcd_fb_arbiter;

  localparam int AW = 22;
  localparam int DW = 16;

  typedef struct {
    int num;
    int hdly;
    int base;
    int wbase;
    bit bank;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          line_req = 1'b0;
  logic [9:0]    line_num = '0;
  logic          host_req = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata, w_mem_rdata;

  logic          host_ack, mem_req, mem_we, lb_we, line_done, underrun;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, lb_wdata;
  logic [10:0]   lb_addr;

  logic          w_host_ack, w_mem_req, w_mem_we, w_lb_we, w_line_done, w_underrun;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata, w_lb_wdata;
  logic [10:0]   w_lb_addr;

  always #5 CLK = ~CLK;

  int ack_dly = 0;
  int wait_cnt;
  assign mem_ack     = mem_req && (wait_cnt >= ack_dly);
  assign mem_rdata   = mem_addr[15:0] ^ 16'h5A5A;
  assign w_mem_rdata = w_mem_addr[15:0] ^ 16'h5A5A;

  always @(posedge CLK or posedge RST) begin
    if (RST)                   wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  lcd_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(32), .BURST_LEN(8), .HOST_MAX(2),
                   .FB_BASE(0)) dut (
    .CLK(CLK), .RST(RST), .line_req(line_req), .line_num(line_num), .host_req(host_req),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .line_done(line_done), .underrun(underrun));

  lcd_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(32), .BURST_LEN(8), .HOST_MAX(2),
                   .FB_BASE(32'd4194272)) dut_w (
    .CLK(CLK), .RST(RST), .line_req(line_req), .line_num(line_num), .host_req(host_req),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(w_host_ack), .mem_req(w_mem_req),
    .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(w_mem_rdata), .lb_we(w_lb_we), .lb_addr(w_lb_addr), .lb_wdata(w_lb_wdata),
    .line_done(w_line_done), .underrun(w_underrun));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Transaction log
  logic          ops[256];
  logic [AW-1:0] rd_a[128], rdw_a[128], wr_a[128];
  logic [DW-1:0] wr_d[128], lb_d[128];
  logic [10:0]   lb_a[128];
  int n_ops, n_rd, n_wr, n_lb, n_done, n_hack, n_host;
  int first_rd_cyc, first_req_cyc, last_lb_cyc, done_cyc, lreq_cyc;
  bit seen_req, first_we, hack, host_stop;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clr();
    n_ops = 0; n_rd = 0; n_wr = 0; n_lb = 0; n_done = 0; n_hack = 0; n_host = 0;
    first_rd_cyc = -1; first_req_cyc = -1; last_lb_cyc = -1; done_cyc = -1;
    seen_req = 0; first_we = 0; hack = 0; host_stop = 0;
  endtask

  // Sample outputs at the falling edge, then move to just after the next rising edge.
  task automatic tick();
    @(negedge CLK);
    if (mem_req && mem_ack) begin
      if (n_ops < 256) ops[n_ops] = mem_we;
      n_ops++;
      if (!mem_we) begin
        if (n_rd < 128) begin rd_a[n_rd] = mem_addr; rdw_a[n_rd] = w_mem_addr; end
        if (n_rd == 0) first_rd_cyc = cyc;
        n_rd++;
      end else begin
        if (n_wr < 128) begin wr_a[n_wr] = mem_addr; wr_d[n_wr] = mem_wdata; end
        n_wr++;
      end
    end
    if (mem_req && !seen_req) begin seen_req = 1; first_req_cyc = cyc; first_we = mem_we; end
    hack = host_ack;
    if (host_ack) n_hack++;
    if (lb_we) begin
      if (n_lb < 128) begin lb_a[n_lb] = lb_addr; lb_d[n_lb] = lb_wdata; end
      n_lb++;
      last_lb_cyc = cyc;
    end
    if (line_done) begin n_done++; done_cyc = cyc; end
    @(posedge CLK);
    #1;
    cyc++;
    line_req = 1'b0;
    if (hack) begin
      if (host_stop) host_req = 1'b0;
      else begin
        n_host++;
        host_addr  = 22'h1000 + 22'(n_host);
        host_wdata = 16'hB000 + 16'(n_host);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    bit ok;
    clr();
    host_addr  = 22'h1000;
    host_wdata = 16'hB000;
    line_num   = 10'(v.num);
    line_req   = 1'b1;
    lreq_cyc   = cyc;
    if (v.hdly == 0) host_req = 1'b1;
    for (int k = 0; k < 400 && n_done == 0; k++) begin
      if (v.hdly > 0 && k == v.hdly) host_req = 1'b1;
      tick();
    end
    chk($sformatf("v%0d_done_seen", id), n_done == 1, n_done, 1);
    host_stop = 1;
    for (int k = 0; k < 40; k++) tick();
    if (host_req) host_req = 1'b0;

    chk($sformatf("v%0d_first_req", id), first_req_cyc - lreq_cyc == 1 && first_we == 0,
        first_req_cyc - lreq_cyc, 1);
    chk($sformatf("v%0d_reads", id), n_rd == 32, n_rd, 32);
    ok = (n_rd >= 32);
    for (int k = 0; k < 32; k++) if (ok && rd_a[k] != 22'(v.base + k)) ok = 0;
    chk($sformatf("v%0d_rd_addr", id), ok, rd_a[0], v.base);
    ok = (n_rd >= 32);
    for (int k = 0; k < 32; k++) if (ok && rdw_a[k] != 22'(v.wbase + k)) ok = 0;
    chk($sformatf("v%0d_wrap_addr", id), ok, rdw_a[0], v.wbase);
    ok = (n_lb == 32);
    for (int k = 0; k < 32; k++)
      if (ok && (lb_a[k] != {v.bank, 10'(k)} || lb_d[k] != (16'(v.base + k) ^ 16'h5A5A))) ok = 0;
    chk($sformatf("v%0d_lb_seq", id), ok, lb_a[0], {v.bank, 10'd0});
    chk($sformatf("v%0d_done_timing", id), done_cyc == last_lb_cyc + 1 && n_done == 1,
        done_cyc - last_lb_cyc, 1);
    if (v.hdly >= 0) begin
      // Expect R x8, W x2 repeating until the last read (38 transactions).
      ok = (n_ops >= 38);
      for (int k = 0; k < 38; k++) if (ok && ops[k] != ((k % 10) >= 8)) ok = 0;
      chk($sformatf("v%0d_interleave", id), ok, n_ops, 38);
      ok = (n_wr >= 6) && (n_hack == n_wr);
      for (int k = 0; k < n_wr && k < 128; k++)
        if (wr_a[k] != 22'h1000 + 22'(k) || wr_d[k] != 16'hB000 + 16'(k)) ok = 0;
      chk($sformatf("v%0d_host_writes", id), ok, n_hack, n_wr);
    end else begin
      chk($sformatf("v%0d_no_stall", id), done_cyc - lreq_cyc == 34 && n_wr == 0,
          done_cyc - lreq_cyc, 34);
    end
  endtask

  vec_t vecs[4];
  vec_t vrst;
  bit   ok;

  initial begin
    vecs[0] = '{num: 3,    hdly: -1, base: 96,    wbase: 64,    bank: 1'b0};
    vecs[1] = '{num: 7,    hdly: 2,  base: 224,   wbase: 192,   bank: 1'b1};
    vecs[2] = '{num: 10,   hdly: 0,  base: 320,   wbase: 288,   bank: 1'b0};
    vecs[3] = '{num: 1023, hdly: -1, base: 32736, wbase: 32704, bank: 1'b1};
    vrst    = '{num: 2,    hdly: -1, base: 64,    wbase: 32,    bank: 1'b0};

    #1 RST = 1'b1;
    #1;
    chk("reset_ctl", {mem_req, mem_we, host_ack, lb_we, line_done, underrun} == 6'd0,
        {mem_req, mem_we, host_ack, lb_we, line_done, underrun}, 0);
    chk("reset_bus", mem_addr == 0 && mem_wdata == 0 && lb_addr == 0 && lb_wdata == 0,
        mem_addr, 0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Underrun: second line_req while word 20 of line 5 is in flight, slow memory.
    ack_dly = 3;
    clr();
    chk("pre_underrun", underrun == 0, underrun, 0);
    line_num = 10'd5;
    line_req = 1'b1;
    ok = 0;
    for (int k = 0; k < 800 && !(n_rd >= 53 && n_done >= 1); k++) begin
      tick();
      if (!ok && mem_req && !mem_we && !mem_ack && mem_addr == 22'd180) begin
        line_num = 10'd6;
        line_req = 1'b1;
        ok = 1;
      end
    end
    for (int k = 0; k < 8; k++) tick();
    chk("ur_flag", underrun == 1, underrun, 1);
    chk("ur_reads", n_rd == 53, n_rd, 53);
    chk("ur_inflight_done", n_rd > 20 && rd_a[20] == 22'd180, rd_a[20], 180);
    chk("ur_restart_addr", n_rd > 21 && rd_a[21] == 22'd192, rd_a[21], 192);
    chk("ur_one_done", n_done == 1, n_done, 1);
    chk("ur_same_bank", n_lb == 53 && lb_a[0] == 11'd0 && lb_a[21] == 11'd0 && lb_a[52] == 11'd31,
        lb_a[21], 0);

    // Asynchronous reset while a host write is outstanding.
    clr();
    host_addr  = 22'h2345;
    host_wdata = 16'hBEEF;
    host_req   = 1'b1;
    for (int k = 0; k < 10 && !(mem_req && mem_we); k++) tick();
    chk("host_pending", mem_req && mem_we && mem_addr == 22'h2345 && mem_wdata == 16'hBEEF,
        mem_addr, 22'h2345);
    RST = 1'b1;
    #1;
    chk("async_rst_ctl", {mem_req, mem_we, host_ack, lb_we, line_done, underrun} == 6'd0,
        {mem_req, mem_we, host_ack, lb_we, line_done, underrun}, 0);
    chk("async_rst_bus", mem_addr == 0 && mem_wdata == 0 && lb_addr == 0 && lb_wdata == 0,
        mem_wdata, 0);
    host_req = 1'b0;
    ack_dly  = 0;
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
    tick();
    tick();
    chk("post_rst_idle", mem_req == 0 && underrun == 0, {mem_req, underrun}, 0);
    run_vec(vrst, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
